// File: rtl/score_ctrl_if.sv
// Purpose : signal bundle between the pong game logic and score_ctrl.
//           The clock and reset are not part of this bundle; they are
//           plain ports on score_ctrl.
// Modports:
//   slave  - score_ctrl side. It receives frame_tick_i, start_i,
//            player_miss_i and enemy_miss_i, and it drives the scores
//            and the game status flags.
//   master - game/test side. This is the opposite direction of slave.
// Signals:
//   frame_tick_i    one-cycle pulse per VGA frame
//   start_i         start/restart request (level)
//   player_miss_i   one-cycle pulse, ball passed player edge
//   enemy_miss_i    one-cycle pulse, ball passed enemy edge
//   player_score_o  player points
//   enemy_score_o   enemy points
//   game_active_o   paddles/ball may move
//   ball_rst_o      one-cycle pulse, re-centre ball
//   score_blink_o   score display enable
//   game_over_o     match finished
//   winner_o        0 = player won, 1 = enemy won
interface score_ctrl_if;
    logic       frame_tick_i;
    logic       start_i;
    logic       player_miss_i;
    logic       enemy_miss_i;
    logic [3:0] player_score_o;
    logic [3:0] enemy_score_o;
    logic       game_active_o;
    logic       ball_rst_o;
    logic       score_blink_o;
    logic       game_over_o;
    logic       winner_o;

    modport slave (
        input  frame_tick_i, start_i, player_miss_i, enemy_miss_i,
        output player_score_o, enemy_score_o, game_active_o, ball_rst_o,
               score_blink_o, game_over_o, winner_o
    );

    modport master (
        output frame_tick_i, start_i, player_miss_i, enemy_miss_i,
        input  player_score_o, enemy_score_o, game_active_o, ball_rst_o,
               score_blink_o, game_over_o, winner_o
    );
endinterface

// File: rtl/score_ctrl.sv
// Purpose : match controller for pong. The states are
//           IDLE -> SERVE freeze -> PLAY -> POINT freeze -> SERVE or OVER.
//           Every output comes straight from a register.
// Ports   :
//   clk_i   pixel clock
//   rst_ni  asynchronous active-low reset
//   bus     score_ctrl_if.slave. It carries the tick, start and miss
//           inputs and the score/status outputs.
// Params  :
//   MAX_SCORE     points needed to win (1..15)
//   SERVE_FRAMES  frames of pre-serve freeze
//   POINT_FRAMES  frames of post-point freeze
module score_ctrl #(
    parameter int unsigned MAX_SCORE    = 9,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90
) (
    input logic          clk_i,
    input logic          rst_ni,
    score_ctrl_if.slave  bus
);

    localparam int unsigned MAXF = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int unsigned CW   = $clog2(MAXF + 1);

    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [CW-1:0] POINT_LAST = CW'(POINT_FRAMES - 1);
    localparam logic [CW-1:0] BLINK_MASK = CW'(7);
    localparam logic [3:0]    MAX4       = 4'(MAX_SCORE);

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        POINT,
        OVER
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    ps_q, ps_d;
    logic [3:0]    es_q, es_d;
    logic          act_q, act_d;
    logic          br_q, br_d;
    logic          blink_q, blink_d;
    logic          over_q, over_d;
    logic          win_q, win_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ps_q    <= '0;
            es_q    <= '0;
            act_q   <= 1'b0;
            br_q    <= 1'b0;
            blink_q <= 1'b1;
            over_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps_d;
            es_q    <= es_d;
            act_q   <= act_d;
            br_q    <= br_d;
            blink_q <= blink_d;
            over_q  <= over_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ps_d    = ps_q;
        es_d    = es_q;
        blink_d = blink_q;
        win_d   = win_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = SERVE;
                    ps_d    = '0;
                    es_d    = '0;
                end
            end
            SERVE: begin
                if (bus.frame_tick_i) begin
                    if (cnt_q == SERVE_LAST) state_d = PLAY;
                    else                     cnt_d   = cnt_q + 1'b1;
                end
            end
            PLAY: begin
                // A miss wins over a coincident frame tick. The counter
                // clears on the state change below, so that tick is never
                // counted.
                if (bus.player_miss_i && bus.enemy_miss_i) begin
                    state_d = POINT;
                end else if (bus.player_miss_i) begin
                    state_d = POINT;
                    if (es_q < MAX4) es_d = es_q + 1'b1;
                end else if (bus.enemy_miss_i) begin
                    state_d = POINT;
                    if (ps_q < MAX4) ps_d = ps_q + 1'b1;
                end
            end
            POINT: begin
                if (bus.frame_tick_i) begin
                    if (cnt_q == POINT_LAST) begin
                        if (ps_q == MAX4 || es_q == MAX4) begin
                            state_d = OVER;
                            win_d   = (es_q == MAX4);
                        end else begin
                            state_d = SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        // Toggle on every 8th tick counted in this freeze.
                        if ((cnt_d & BLINK_MASK) == '0) blink_d = ~blink_q;
                    end
                end
            end
            OVER: begin
                if (bus.start_i) begin
                    state_d = SERVE;
                    ps_d    = '0;
                    es_d    = '0;
                    win_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Blink restarts at 0 when POINT is entered. Outside POINT it is forced to 1.
        if (state_d != POINT)       blink_d = 1'b1;
        else if (state_q != POINT)  blink_d = 1'b0;

        act_d  = (state_d == PLAY);
        over_d = (state_d == OVER);
        br_d   = (state_d == SERVE) && (state_q != SERVE);
    end

    assign bus.player_score_o = ps_q;
    assign bus.enemy_score_o  = es_q;
    assign bus.game_active_o  = act_q;
    assign bus.ball_rst_o     = br_q;
    assign bus.score_blink_o  = blink_q;
    assign bus.game_over_o    = over_q;
    assign bus.winner_o       = win_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Purpose : testbench for score_ctrl with the default parameters
//           (9 points, 60 and 90 frame freezes). It runs table-driven
//           cycle vectors and then hand-written sequences for match end
//           and for reset in the middle of a point.
module tb_score_ctrl;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    score_ctrl_if bus ();

    score_ctrl dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // in  = {frame_tick, start, player_miss, enemy_miss}, held for reps cycles
    // fl  = {game_active, ball_rst, score_blink, game_over, winner}
    typedef struct {
        logic [3:0]  in;
        int unsigned reps;
        logic [3:0]  ps;
        logic [3:0]  es;
        logic [4:0]  fl;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ps, input logic [3:0] es,
                           input logic [4:0] fl);
        chk({tag, ".player_score"}, bus.player_score_o, ps);
        chk({tag, ".enemy_score"},  bus.enemy_score_o,  es);
        chk({tag, ".game_active"},  {3'b0, bus.game_active_o}, {3'b0, fl[4]});
        chk({tag, ".ball_rst"},     {3'b0, bus.ball_rst_o},    {3'b0, fl[3]});
        chk({tag, ".score_blink"},  {3'b0, bus.score_blink_o}, {3'b0, fl[2]});
        chk({tag, ".game_over"},    {3'b0, bus.game_over_o},   {3'b0, fl[1]});
        chk({tag, ".winner"},       {3'b0, bus.winner_o},      {3'b0, fl[0]});
    endtask

    // Inputs are applied just after a rising edge. Outputs are sampled 1 ns after the next one.
    task automatic step(input logic [3:0] in, input int unsigned reps);
        for (int unsigned i = 0; i < reps; i++) begin
            {bus.frame_tick_i, bus.start_i, bus.player_miss_i, bus.enemy_miss_i} = in;
            @(posedge clk_i);
            #1;
        end
        {bus.frame_tick_i, bus.start_i, bus.player_miss_i, bus.enemy_miss_i} = 4'b0000;
    endtask

    // From SERVE (counter 0): 60 ticks to PLAY, one miss, then the full 90-tick freeze.
    task automatic play_point(input logic [3:0] miss);
        step(4'b1000, 60);
        step(miss, 1);
        step(4'b1000, 90);
    endtask

    initial begin
        {bus.frame_tick_i, bus.start_i, bus.player_miss_i, bus.enemy_miss_i} = 4'b0000;

        vecs.push_back(vec_t'{4'b0000,  2, 4'd0, 4'd0, 5'b00100}); // idle
        vecs.push_back(vec_t'{4'b0011,  1, 4'd0, 4'd0, 5'b00100}); // misses in IDLE
        vecs.push_back(vec_t'{4'b1000,  3, 4'd0, 4'd0, 5'b00100}); // ticks in IDLE
        vecs.push_back(vec_t'{4'b0100,  1, 4'd0, 4'd0, 5'b01100}); // start -> SERVE pulse
        vecs.push_back(vec_t'{4'b0000,  1, 4'd0, 4'd0, 5'b00100}); // pulse is 1 cycle
        vecs.push_back(vec_t'{4'b0010,  1, 4'd0, 4'd0, 5'b00100}); // miss in SERVE
        vecs.push_back(vec_t'{4'b1000, 59, 4'd0, 4'd0, 5'b00100}); // 59 ticks
        vecs.push_back(vec_t'{4'b0100,  1, 4'd0, 4'd0, 5'b00100}); // start in SERVE
        vecs.push_back(vec_t'{4'b1000,  1, 4'd0, 4'd0, 5'b10100}); // 60th tick -> PLAY
        vecs.push_back(vec_t'{4'b0100,  1, 4'd0, 4'd0, 5'b10100}); // start in PLAY
        vecs.push_back(vec_t'{4'b1000,  5, 4'd0, 4'd0, 5'b10100}); // ticks in PLAY
        vecs.push_back(vec_t'{4'b0001,  1, 4'd1, 4'd0, 5'b00000}); // enemy miss -> player+1
        vecs.push_back(vec_t'{4'b1000,  7, 4'd1, 4'd0, 5'b00000}); // tick 7
        vecs.push_back(vec_t'{4'b1000,  1, 4'd1, 4'd0, 5'b00100}); // tick 8 toggles
        vecs.push_back(vec_t'{4'b1000,  8, 4'd1, 4'd0, 5'b00000}); // tick 16 toggles
        vecs.push_back(vec_t'{4'b0011,  1, 4'd1, 4'd0, 5'b00000}); // misses in POINT
        vecs.push_back(vec_t'{4'b0100,  1, 4'd1, 4'd0, 5'b00000}); // start in POINT
        vecs.push_back(vec_t'{4'b1000, 73, 4'd1, 4'd0, 5'b00100}); // tick 89
        vecs.push_back(vec_t'{4'b1000,  1, 4'd1, 4'd0, 5'b01100}); // tick 90 -> SERVE
        vecs.push_back(vec_t'{4'b1000, 60, 4'd1, 4'd0, 5'b10100}); // -> PLAY
        vecs.push_back(vec_t'{4'b0011,  1, 4'd1, 4'd0, 5'b00000}); // both miss: replay
        vecs.push_back(vec_t'{4'b1000, 90, 4'd1, 4'd0, 5'b01100}); // -> SERVE
        vecs.push_back(vec_t'{4'b1000, 60, 4'd1, 4'd0, 5'b10100}); // -> PLAY
        vecs.push_back(vec_t'{4'b1010,  1, 4'd1, 4'd1, 5'b00000}); // miss + tick
        vecs.push_back(vec_t'{4'b1000,  7, 4'd1, 4'd1, 5'b00000}); // tick not counted
        vecs.push_back(vec_t'{4'b1000, 82, 4'd1, 4'd1, 5'b00100}); // tick 89
        vecs.push_back(vec_t'{4'b1000,  1, 4'd1, 4'd1, 5'b01100}); // tick 90 -> SERVE

        // Reset values, while reset is held and then after release.
        repeat (3) @(posedge clk_i);
        #1;
        chk_all("rst_hold", 4'd0, 4'd0, 5'b00100);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].in, vecs[i].reps);
            chk_all($sformatf("v%0d", i), vecs[i].ps, vecs[i].es, vecs[i].fl);
        end

        // Score is 1:1 and the DUT is in SERVE. The player needs 8 more points to win.
        for (int k = 0; k < 7; k++) play_point(4'b0001);
        chk_all("p8", 4'd8, 4'd1, 5'b01100);
        play_point(4'b0001);
        chk_all("over", 4'd9, 4'd1, 5'b00110);
        step(4'b0001, 1);
        step(4'b0010, 1);
        step(4'b1011, 100);
        chk_all("over_hold", 4'd9, 4'd1, 5'b00110);
        step(4'b0100, 1);
        chk_all("restart", 4'd0, 4'd0, 5'b01100);

        // Bring the score to 3:5, then reset in the middle of the POINT freeze.
        for (int k = 0; k < 3; k++) play_point(4'b0001);
        for (int k = 0; k < 4; k++) play_point(4'b0010);
        step(4'b1000, 60);
        step(4'b0010, 1);
        step(4'b1000, 40);
        chk_all("pt_3_5", 4'd3, 4'd5, 5'b00100);
        #3 rst_ni = 1'b0;
        #1;
        chk_all("async_rst", 4'd0, 4'd0, 5'b00100);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        step(4'b1011, 100);
        chk_all("idle_after", 4'd0, 4'd0, 5'b00100);
        step(4'b0100, 1);
        chk_all("start_after", 4'd0, 4'd0, 5'b01100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
